// File: rtl/uart_tx_fifo.sv
// FIFO-buffered UART transmitter: runtime prescale/parity/stop selection and line break.
// Frame config is captured when a word (or a break) starts, so mid-frame changes wait for the next frame.
module uart_tx_fifo #(
  parameter int DATA_BITS  = 8,
  parameter int FIFO_DEPTH = 16,
  parameter int PRESCALE_W = 16
) (
  input  logic                          clk_i,
  input  logic                          rstn_i,
  input  logic [PRESCALE_W-1:0]         prescale_i,
  input  logic [1:0]                    parity_i,
  input  logic                          stop2_i,
  input  logic                          break_i,
  input  logic [DATA_BITS-1:0]          s_axis_tdata,
  input  logic                          s_axis_tvalid,
  output logic                          s_axis_tready,
  output logic                          txd_o,
  output logic                          busy_o,
  output logic [$clog2(FIFO_DEPTH):0]   level_o
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int TW = PRESCALE_W + 3;
  localparam int BW = 4;

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_BREAK, S_MARK
  } state_e;

  typedef struct packed {
    logic [PRESCALE_W-1:0] presc;
    logic [1:0]            parity;
    logic                  stop2;
  } cfg_t;

  state_e                 state_q, state_d;
  cfg_t                   cfg_q, cfg_d, cfg_in;
  logic [DATA_BITS-1:0]   shift_q, shift_d;
  logic                   par_q, par_d;
  logic [TW-1:0]          timer_q, timer_d;
  logic [TW-1:0]          reload_cur, reload_new;
  logic [BW-1:0]          bit_q, bit_d, brk_last;
  logic                   min_q, min_d;
  logic                   txd_q, txd_d;
  logic                   busy_q, busy_d;
  logic                   rdy_q, rdy_d;
  logic [CW-1:0]          count_q, count_d;
  logic [AW-1:0]          wr_q, wr_d, rd_q, rd_d;
  logic [DATA_BITS-1:0]   mem_q [FIFO_DEPTH];
  logic [DATA_BITS-1:0]   head;
  logic                   push, pop, tick;

  // prescale of 0 behaves as 1 so a bit is never shorter than 8 clocks
  always_comb begin
    cfg_in        = '0;
    cfg_in.presc  = (prescale_i == '0) ? PRESCALE_W'(1) : prescale_i;
    cfg_in.parity = parity_i;
    cfg_in.stop2  = stop2_i;
  end

  assign reload_new = {cfg_in.presc, 3'b000} - TW'(1);
  assign reload_cur = {cfg_q.presc, 3'b000} - TW'(1);
  assign tick       = (timer_q == '0);
  // index of the last bit period of a full frame, used as the minimum break length
  assign brk_last   = BW'(DATA_BITS + 1) + BW'(cfg_q.parity != 2'b00) + BW'(cfg_q.stop2);
  assign head       = mem_q[rd_q];

  assign s_axis_tready = rdy_q & (count_q != CW'(FIFO_DEPTH));
  assign push          = s_axis_tvalid & s_axis_tready;
  assign rdy_d         = 1'b1;

  always_comb begin
    state_d = state_q;
    cfg_d   = cfg_q;
    shift_d = shift_q;
    par_d   = par_q;
    bit_d   = bit_q;
    min_d   = min_q;
    timer_d = tick ? reload_cur : timer_q - TW'(1);
    txd_d   = 1'b1;
    pop     = 1'b0;
    case (state_q)
      S_IDLE: begin
        timer_d = reload_new;
        bit_d   = '0;
        min_d   = 1'b0;
        if (break_i) begin
          cfg_d   = cfg_in;
          state_d = S_BREAK;
        end else if (count_q != '0) begin
          pop     = 1'b1;
          cfg_d   = cfg_in;
          shift_d = head;
          case (parity_i)
            2'b01:   par_d = ~^head;
            2'b10:   par_d = ^head;
            default: par_d = 1'b0;
          endcase
          state_d = S_START;
        end
      end
      S_START: begin
        txd_d = 1'b0;
        if (tick) state_d = S_DATA;
      end
      S_DATA: begin
        txd_d = shift_q[0];
        if (tick) begin
          shift_d = shift_q >> 1;
          if (bit_q == BW'(DATA_BITS - 1)) begin
            bit_d   = '0;
            state_d = (cfg_q.parity != 2'b00) ? S_PARITY : S_STOP;
          end else begin
            bit_d = bit_q + BW'(1);
          end
        end
      end
      S_PARITY: begin
        txd_d = par_q;
        if (tick) state_d = S_STOP;
      end
      S_STOP: begin
        if (tick) begin
          if (cfg_q.stop2 && bit_q == '0) bit_d = BW'(1);
          else state_d = S_IDLE;
        end
      end
      S_BREAK: begin
        txd_d = 1'b0;
        // once the minimum is met, release follows break_i without waiting for a bit boundary
        if (min_q) begin
          if (!break_i) begin
            timer_d = reload_cur;
            state_d = S_MARK;
          end
        end else if (tick) begin
          if (bit_q == brk_last) begin
            if (!break_i) state_d = S_MARK;
            else min_d = 1'b1;
          end else begin
            bit_d = bit_q + BW'(1);
          end
        end
      end
      S_MARK: begin
        if (tick) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    count_d = count_q;
    wr_d    = push ? wr_q + AW'(1) : wr_q;
    rd_d    = pop  ? rd_q + AW'(1) : rd_q;
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
    busy_d = (state_d != S_IDLE) || (count_d != '0);
  end

  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      state_q <= S_IDLE;
      cfg_q   <= '0;
      shift_q <= '0;
      par_q   <= 1'b0;
      timer_q <= '0;
      bit_q   <= '0;
      min_q   <= 1'b0;
      txd_q   <= 1'b1;
      busy_q  <= 1'b0;
      rdy_q   <= 1'b0;
      count_q <= '0;
      wr_q    <= '0;
      rd_q    <= '0;
    end else begin
      state_q <= state_d;
      cfg_q   <= cfg_d;
      shift_q <= shift_d;
      par_q   <= par_d;
      timer_q <= timer_d;
      bit_q   <= bit_d;
      min_q   <= min_d;
      txd_q   <= txd_d;
      busy_q  <= busy_d;
      rdy_q   <= rdy_d;
      count_q <= count_d;
      wr_q    <= wr_d;
      rd_q    <= rd_d;
    end
  end

  // storage needs no reset; the pointers define what is valid
  always_ff @(posedge clk_i) begin
    if (push) mem_q[wr_q] <= s_axis_tdata;
  end

  assign txd_o   = txd_q;
  assign busy_o  = busy_q;
  assign level_o = count_q;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo: a queue-of-line-levels model checked every cycle, plus literal waveform pins.
module tb_uart_tx_fifo;
  localparam int DB = 8, DEPTH = 16, PW = 16, LW = $clog2(DEPTH) + 1;

  logic clk = 1'b0, rstn = 1'b0;
  logic [PW-1:0] prescale = PW'(2);
  logic [1:0] parity = 2'b00;
  logic stop2 = 1'b0, brk = 1'b0;
  logic [DB-1:0] tdata = '0;
  logic tvalid = 1'b0;
  logic tready, txd, busy;
  logic [LW-1:0] level;

  uart_tx_fifo #(.DATA_BITS(DB), .FIFO_DEPTH(DEPTH), .PRESCALE_W(PW)) dut (
    .clk_i(clk), .rstn_i(rstn), .prescale_i(prescale), .parity_i(parity),
    .stop2_i(stop2), .break_i(brk), .s_axis_tdata(tdata), .s_axis_tvalid(tvalid),
    .s_axis_tready(tready), .txd_o(txd), .busy_o(busy), .level_o(level)
  );

  always #5 clk = ~clk;

  int total = 0, bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: mq holds the line level expected after each future clock edge.
  logic mq[$];
  logic [DB-1:0] mf[$];
  bit   m_brk = 1'b0, chk_en = 1'b0;
  int   m_bitlen = 8;
  logic e_txd = 1'b1, e_busy = 1'b0, e_rdy = 1'b0;
  int   e_lvl = 0;

  function automatic int bit_cycles(input logic [PW-1:0] p);
    return ((p == '0) ? 1 : int'(p)) * 8;
  endfunction

  always @(posedge clk) begin
    bit m_idle, m_push;
    logic [DB-1:0] w;
    logic pb;
    int bl, nbits;
    if (!rstn) begin
      mq.delete(); mf.delete();
      m_brk = 1'b0; e_txd = 1'b1; e_lvl = 0; e_busy = 1'b0; e_rdy = 1'b0;
    end else begin
      m_push = tvalid && e_rdy && (mf.size() != DEPTH);
      m_idle = (mq.size() == 0);
      e_txd  = m_idle ? 1'b1 : mq.pop_front();
      if (!m_idle && m_brk && mq.size() == 0) begin
        if (brk) mq.push_back(1'b0);
        else begin
          m_brk = 1'b0;
          repeat (m_bitlen) mq.push_back(1'b1);
        end
      end
      if (m_idle) begin
        bl = bit_cycles(prescale);
        if (brk) begin
          nbits = 1 + DB + ((parity != 2'b00) ? 1 : 0) + (stop2 ? 2 : 1);
          repeat (nbits * bl) mq.push_back(1'b0);
          m_brk = 1'b1;
          m_bitlen = bl;
        end else if (mf.size() != 0) begin
          w = mf.pop_front();
          repeat (bl) mq.push_back(1'b0);
          for (int i = 0; i < DB; i++) repeat (bl) mq.push_back(w[i]);
          if (parity != 2'b00) begin
            if (parity == 2'b01) pb = ($countones(w) % 2 == 0);
            else if (parity == 2'b10) pb = ($countones(w) % 2 == 1);
            else pb = 1'b0;
            repeat (bl) mq.push_back(pb);
          end
          repeat (bl * (stop2 ? 2 : 1)) mq.push_back(1'b1);
        end
      end
      if (m_push) mf.push_back(tdata);
      e_lvl  = mf.size();
      e_busy = (mq.size() != 0) || (e_lvl != 0);
      e_rdy  = 1'b1;
    end
    chk_en = 1'b1;
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("txd",    32'(txd),    32'(e_txd));
      check("busy",   32'(busy),   32'(e_busy));
      check("level",  32'(level),  32'(e_lvl));
      check("tready", 32'(tready), 32'(e_rdy && (e_lvl != DEPTH)));
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic push1(input logic [DB-1:0] d);
    tdata = d; tvalid = 1'b1;
    @(negedge clk);
    tvalid = 1'b0;
  endtask

  task automatic wait_idle(input int limit);
    int n;
    n = 0;
    while (busy !== 1'b0 && n < limit) begin
      @(negedge clk);
      n++;
    end
    check("idle_reached", 32'(busy), 32'd0);
    tick(2);
  endtask

  // Push one word from idle and sample the middle of each bit period; config is scrambled mid-frame.
  task automatic frame_sample(input logic [DB-1:0] d, input int nb, input int bl, output logic [15:0] bits);
    logic [PW-1:0] sp;
    logic [1:0] spar;
    logic ss;
    sp = prescale; spar = parity; ss = stop2;
    bits = '0;
    push1(d);
    tick(1);
    check("idle_before_start", 32'(txd), 32'd1);
    tick(1);
    check("start_latency", 32'(txd), 32'd0);
    prescale = PW'(9); parity = ~spar; stop2 = ~ss;
    tick(bl / 2);
    bits[0] = txd;
    for (int i = 1; i < nb; i++) begin
      tick(bl);
      bits[i] = txd;
    end
    prescale = sp; parity = spar; stop2 = ss;
  endtask

  logic [15:0] bits;
  logic [DB-1:0] fw [18];
  int k, guard, hold;
  bit acc;

  initial begin
    tick(3);
    check("rst_txd", 32'(txd), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_level", 32'(level), 32'd0);
    check("rst_tready", 32'(tready), 32'd0);
    rstn = 1'b1;
    tick(1);
    check("tready_after_release", 32'(tready), 32'd1);
    tick(2);

    // 8N1, prescale 2: 16 cycles per bit, 160-cycle frame
    prescale = PW'(2); parity = 2'b00; stop2 = 1'b0;
    frame_sample(8'h55, 10, 16, bits);
    check("bits_55", 32'(bits), 32'h2AA);
    tick(6);
    check("busy_last_frame_cycle", 32'(busy), 32'd1);
    tick(1);
    check("busy_after_frame", 32'(busy), 32'd0);
    wait_idle(100);

    parity = 2'b10;
    frame_sample(8'h07, 11, 16, bits);
    check("bits_even_07", 32'(bits), 32'h60E);
    wait_idle(300);
    parity = 2'b01;
    frame_sample(8'h07, 11, 16, bits);
    check("bits_odd_07", 32'(bits), 32'h40E);
    wait_idle(300);
    parity = 2'b11;
    frame_sample(8'h07, 11, 16, bits);
    check("bits_space_07", 32'(bits), 32'h40E);
    wait_idle(300);

    // two stop bits: frame occupies 11 bit periods
    parity = 2'b00; stop2 = 1'b1;
    frame_sample(8'h07, 11, 16, bits);
    check("bits_stop2_07", 32'(bits), 32'h60E);
    tick(6);
    check("stop2_busy_end", 32'(busy), 32'd1);
    tick(1);
    check("stop2_idle", 32'(busy), 32'd0);
    wait_idle(100);
    stop2 = 1'b0;

    // fill the FIFO with tvalid held high
    prescale = PW'(4);
    for (int i = 0; i < 18; i++) fw[i] = DB'(i * 37 + 11);
    k = 0; guard = 0; tvalid = 1'b1; tdata = fw[0];
    while (k < 17 && guard < 200) begin
      acc = tready;
      @(negedge clk);
      guard++;
      if (acc) begin
        k++;
        tdata = fw[k];
      end
    end
    check("full_level", 32'(level), 32'd16);
    check("full_tready", 32'(tready), 32'd0);
    while (k < 18 && guard < 3000) begin
      acc = tready;
      @(negedge clk);
      guard++;
      if (acc) k++;
    end
    tvalid = 1'b0;
    check("accept18", 32'(k), 32'd18);
    wait_idle(8000);

    // one-cycle break at prescale 1: 80 low, 8 high, then the queued word
    prescale = PW'(1);
    brk = 1'b1;
    tick(1);
    brk = 1'b0;
    tick(1);
    check("brk_first_low", 32'(txd), 32'd0);
    push1(8'h3C);
    tick(78);
    check("brk_last_low", 32'(txd), 32'd0);
    tick(1);
    check("mark_first", 32'(txd), 32'd1);
    tick(7);
    check("mark_last", 32'(txd), 32'd1);
    check("brk_no_pop", 32'(level), 32'd1);
    tick(1);
    check("pop_after_mark", 32'(txd), 32'd1);
    tick(1);
    check("start_after_mark", 32'(txd), 32'd0);
    wait_idle(300);

    // break raised mid-frame waits for the frame to finish
    push1(8'hFF);
    tick(30);
    brk = 1'b1;
    tick(10);
    check("mid_frame_data", 32'(txd), 32'd1);
    tick(42);
    check("frame_end_idle", 32'(txd), 32'd1);
    tick(1);
    check("brk_after_frame", 32'(txd), 32'd0);
    tick(17);
    brk = 1'b0;
    tick(62);
    check("brk_min_last", 32'(txd), 32'd0);
    tick(1);
    check("brk_mark", 32'(txd), 32'd1);
    wait_idle(300);

    // reset pulse during a data bit
    prescale = PW'(2);
    push1(8'h00); push1(8'h11); push1(8'h22);
    tick(30);
    check("pre_reset_low", 32'(txd), 32'd0);
    rstn = 1'b0;
    tick(1);
    rstn = 1'b1;
    check("rst_mid_txd", 32'(txd), 32'd1);
    check("rst_mid_level", 32'(level), 32'd0);
    check("rst_mid_busy", 32'(busy), 32'd0);
    check("rst_mid_tready", 32'(tready), 32'd0);
    tick(1);
    check("rst_mid_tready_rel", 32'(tready), 32'd1);
    wait_idle(50);

    // random traffic, config churn, breaks and rare resets
    hold = 0;
    for (int c = 0; c < 6000; c++) begin
      tvalid   = ($urandom_range(0, 3) == 0);
      tdata    = DB'($urandom);
      prescale = PW'($urandom_range(0, 3));
      parity   = 2'($urandom);
      stop2    = 1'($urandom);
      if (hold > 0) hold--;
      else if ($urandom_range(0, 399) == 0) hold = $urandom_range(1, 150);
      brk  = (hold > 0);
      rstn = ($urandom_range(0, 2999) != 0);
      @(negedge clk);
    end
    tvalid = 1'b0; brk = 1'b0; rstn = 1'b1;
    wait_idle(20000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
